// File: rtl/decode_pkg.sv
// Shared types, RV32 opcode constants and decode helpers for the decode stage.
// The legality check is only consumed when DECODE_ILLEGAL_TRAP_EN is defined.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS
  } alu_op_t;

  typedef enum logic {
    SRC1_RS1,
    SRC1_PC
  } alu_src1_t;

  typedef enum logic [1:0] {
    SRC2_RS2,
    SRC2_IMM,
    SRC2_FOUR
  } alu_src2_t;

  typedef enum logic [1:0] {
    RD_ALU,
    RD_LSU,
    RD_CSR,
    RD_PC4
  } rd_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    alu_op_t     alu_op;
    alu_src1_t   alu_src1;
    alu_src2_t   alu_src2;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [2:0]  lsu_op;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    rd_sel_t     rd_sel;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic        is_ecall;
    logic        is_mret;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } decode_pkt_t;

  // alt selects SUB/SRA; callers pass it only where the encoding allows it.
  function automatic alu_op_t alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic inst_legal(input logic [31:0] inst);
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       ok;
    funct3 = inst[14:12];
    funct7 = inst[31:25];
    ok     = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL: ok = 1'b1;
      OPC_JALR:     ok = (funct3 == 3'b000);
      OPC_BRANCH:   ok = !(funct3 inside {3'b010, 3'b011});
      OPC_LOAD:     ok = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      OPC_STORE:    ok = (funct3 inside {3'b000, 3'b001, 3'b010});
      OPC_OP_IMM: begin
        if (funct3 == 3'b001)      ok = (funct7 == 7'h00);
        else if (funct3 == 3'b101) ok = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       ok = 1'b1;
      end
      OPC_OP:       ok = (funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && (funct3 inside {3'b000, 3'b101}));
      OPC_MISC_MEM: ok = (funct3 == 3'b000);
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) ok = (inst inside {INST_ECALL, INST_EBREAK, INST_MRET});
        else                  ok = (funct3 != 3'b100);
      end
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the RV32 format from the opcode and sign-extends from inst[31].
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'h000};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I+Zicsr decode stage with a small in-order packet buffer between fetch and execute.
// Optional DECODE_ILLEGAL_TRAP_EN flags unknown encodings and suppresses their side effects.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  output logic [4:0]                 rs1_addr,
  output logic [4:0]                 rs2_addr,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            rs2_data,
  input  logic                       hazard_stall,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output decode_pkt_t                out_pkt,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  decode_pkt_t     buffer [DEPTH];
  decode_pkt_t     dec;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      imm;
  logic             rd_write;
  logic             push;
  logic             pop;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign rd       = in_inst[11:7];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  imm_gen u_imm_gen (
    .inst (in_inst),
    .imm  (imm)
  );

  // Jumps use the ALU to form the link value (pc + 4); the target is computed downstream.
  always_comb begin
    dec          = '0;
    rd_write     = 1'b0;
    dec.pc       = in_pc;
    dec.inst     = in_inst;
    dec.imm      = imm;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.alu_op   = ALU_ADD;
    dec.alu_src1 = SRC1_RS1;
    dec.alu_src2 = SRC2_RS2;
    dec.rd_sel   = RD_ALU;
    dec.lsu_op   = funct3;
    dec.rd_addr  = rd;
    case (opcode)
      OPC_LUI: begin
        dec.alu_op   = ALU_PASS;
        dec.alu_src2 = SRC2_IMM;
        rd_write     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_src1 = SRC1_PC;
        dec.alu_src2 = SRC2_IMM;
        rd_write     = 1'b1;
      end
      OPC_JAL: begin
        dec.is_jal   = 1'b1;
        dec.alu_src1 = SRC1_PC;
        dec.alu_src2 = SRC2_FOUR;
        dec.rd_sel   = RD_PC4;
        rd_write     = 1'b1;
      end
      OPC_JALR: begin
        dec.is_jalr  = 1'b1;
        dec.alu_src1 = SRC1_PC;
        dec.alu_src2 = SRC2_FOUR;
        dec.rd_sel   = RD_PC4;
        rd_write     = 1'b1;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        case (funct3)
          3'b100, 3'b101: dec.alu_op = ALU_SLT;
          3'b110, 3'b111: dec.alu_op = ALU_SLTU;
          default:        dec.alu_op = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        dec.lsu_ren  = 1'b1;
        dec.alu_src2 = SRC2_IMM;
        dec.rd_sel   = RD_LSU;
        rd_write     = 1'b1;
      end
      OPC_STORE: begin
        dec.lsu_wen  = 1'b1;
        dec.alu_src2 = SRC2_IMM;
      end
      OPC_OP_IMM: begin
        dec.alu_op   = alu_op_from_funct3(funct3, (funct3 == 3'b101) && in_inst[30]);
        dec.alu_src2 = SRC2_IMM;
        rd_write     = 1'b1;
      end
      OPC_OP: begin
        dec.alu_op = alu_op_from_funct3(funct3, in_inst[30]);
        rd_write   = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          dec.is_ecall = (in_inst == INST_ECALL);
          dec.is_mret  = (in_inst == INST_MRET);
        end else begin
          // CSRRS/CSRRC with a zero source are pure reads and must not write the CSR.
          dec.rd_sel   = RD_CSR;
          dec.csr_addr = in_inst[31:20];
          dec.csr_wen  = (funct3[1:0] == 2'b01) || (in_inst[19:15] != 5'd0);
          rd_write     = 1'b1;
        end
      end
      default: begin
      end
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    dec.illegal = ~inst_legal(in_inst);
    if (dec.illegal) begin
      rd_write    = 1'b0;
      dec.lsu_ren = 1'b0;
      dec.lsu_wen = 1'b0;
      dec.csr_wen = 1'b0;
    end
`else
    dec.illegal = 1'b0;
`endif
    dec.rd_wen = rd_write && (rd != 5'd0);
  end

  // in_ready depends only on local state so out_ready never reaches it combinationally.
  assign in_ready  = rst_n && (count_q < CNT_W'(DEPTH)) && !hazard_stall && !flush;
  assign out_valid = (count_q != '0);
  assign out_pkt   = buffer[head];
  assign count     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      if (push) begin
        buffer[tail] <= dec;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is legal in this generation.
REQ-002 SHALL have parameter DEPTH, default 2, decoded-packet buffer entries; power of two, >= 2.
REQ-003 SHALL have ports: clk input 1, sole clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid input 1, upstream valid; in_ready output 1, upstream ready; in_pc input XLEN, fetch PC; in_inst input 32, instruction word.
REQ-005 SHALL have ports: rs1_addr output 5, rs2_addr output 5, RF async read addresses; rs1_data input XLEN, rs2_data input XLEN, RF read data.
REQ-006 SHALL have ports: hazard_stall input 1, blocks acceptance; flush input 1, drops all buffered packets.
REQ-007 SHALL have ports: out_valid output 1; out_ready input 1; out_pkt output decode_pkt_t, head-of-buffer decoded packet.
REQ-008 SHALL have port count output $clog2(DEPTH+1), buffer occupancy.

Function
REQ-009 SHALL drive rs1_addr = in_inst[19:15] and rs2_addr = in_inst[24:20] combinationally, independent of handshake.
REQ-010 SHALL accept an instruction on a clock edge where in_valid & in_ready; accept captures pc, inst, decoded fields, imm, rs1_data and rs2_data into the tail entry.
REQ-011 SHALL compute in_ready = (count < DEPTH) & ~hazard_stall & ~flush, with no combinational path from out_ready.
REQ-012 SHALL assert out_valid = (count != 0); out_pkt is the head entry; a pop occurs on out_valid & out_ready.
REQ-013 SHALL give 1-cycle latency: a packet accepted at edge N is visible on out_pkt after edge N when the buffer was empty.
REQ-014 SHALL preserve order; push and pop in the same edge leave count unchanged; with DEPTH=2 and out_ready held high, throughput is 1 packet per cycle.
REQ-015 SHALL wrap head/tail pointers modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-016 SHALL decode per packet: alu_op (alu_op_t), alu_src1 (rs1/pc), alu_src2 (rs2/imm/const 4), lsu_ren, lsu_wen, lsu_op[2:0] = funct3, rd_wen, rd_addr, rd_sel (alu/lsu/csr/pc+4), csr_wen, csr_addr, is_ecall, is_mret, is_branch, is_jal, is_jalr.
REQ-017 SHALL force rd_wen = 0 for branch, store, ecall, mret, and for any rd_addr = 0.
REQ-018 SHALL generate imm for I/S/B/U/J formats, sign-extended from inst[31]; U format has imm[11:0] = 0.
REQ-019 SHALL, on flush at edge N: set count to 0 and invalidate all entries; ignore in_valid that cycle; a simultaneous pop completes from the consumer's view.
REQ-020 SHALL hold out_pkt stable while out_valid & ~out_ready.

Reset
REQ-021 SHALL, while rst_n = 0, clear count, head, tail; out_valid = 0; in_ready = 0; all buffer entries zero so out_pkt = 0.
REQ-022 SHALL treat reset asserted mid-transfer as discarding all packets; first accept is possible at the first edge after rst_n deasserts.

Configuration
REQ-023 SHALL honour macro DECODE_ILLEGAL_TRAP_EN: defined -> packet field illegal = 1 for any opcode/funct outside RV32I+Zicsr+mret; rd_wen, lsu_ren, lsu_wen, csr_wen forced 0 for that packet.
REQ-024 SHALL, without DECODE_ILLEGAL_TRAP_EN, tie illegal = 0 and decode unknown encodings with no defined effect beyond that requirement.

Structure
REQ-025 SHALL place alu_op_t, src-select enums, rd_sel_t, decode_pkt_t and RV32 opcode constants in package decode_pkg.
REQ-026 SHALL implement immediate generation as sub-module imm_gen (inst in, imm out, purely combinational); all sequential logic stays in decode_stage.

Verification
REQ-027 SHALL cover: in_inst 0x00500093 (addi x1,x0,5), pc 0x80000000, out_ready=1 -> next cycle out_valid=1, imm=5, rd_addr=1, rd_wen=1, alu_src2=imm.
REQ-028 SHALL cover: in_inst 0x123450B7 (lui x1) -> imm=0x12345000, rd_sel=alu; in_inst 0xFE000EE3 (beq x0,x0,-4) -> is_branch=1, rd_wen=0, imm=0xFFFFFFFC.
REQ-029 SHALL cover backpressure: out_ready=0, offer 3 instructions -> in_ready=0 after count=2; raise out_ready -> pop in order A,B then accept C.
REQ-030 SHALL cover flush: count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, offered instruction not stored.
REQ-031 SHALL cover hazard_stall=1 with in_valid=1 for 3 cycles -> no accept, buffered packets still drain.
REQ-032 SHALL cover, with DECODE_ILLEGAL_TRAP_EN: in_inst 0x00000000 -> illegal=1, rd_wen=0; rst_n pulsed low with count=1 -> out_valid=0 immediately.
